// File: rtl/stack_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_seq_ctrl
// Brief    : Multi-cycle CALL/RET/INT/RTI stack sequencer with PC redirect.
// Revision : 1.0
// ============================================================================
module stack_seq_ctrl #(
  parameter logic [7:0] INT_VEC_ADDR = 8'h01,
  parameter int         FLAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [7:0]        target,
  input  logic [7:0]        ret_pc,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [7:0]        sp_in,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              stall,
  output logic [7:0]        mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        sp_out,
  output logic              sp_we,
  output logic              pc_load,
  output logic [7:0]        pc_value,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_we,
  output logic              done,
  output logic              int_ack
);

  localparam logic [1:0] OP_CALL = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_INT  = 2'b10;
  localparam logic [1:0] OP_RTI  = 2'b11;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH_PC  = 3'd1;
  localparam logic [2:0] S_PUSH_FLG = 3'd2;
  localparam logic [2:0] S_RD_VEC   = 3'd3;
  localparam logic [2:0] S_POP_FLG  = 3'd4;
  localparam logic [2:0] S_POP_PC   = 3'd5;
  localparam logic [2:0] S_RD_WAIT  = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [7:0]        target_q, target_d;
  logic [7:0]        ret_pc_q, ret_pc_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic [7:0]        sp_q, sp_d;
  logic [7:0]        data_q, data_d;
  logic              flg_phase_q, flg_phase_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      target_q    <= 8'h00;
      ret_pc_q    <= 8'h00;
      flag_q      <= '0;
      sp_q        <= 8'h00;
      data_q      <= 8'h00;
      flg_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      target_q    <= target_d;
      ret_pc_q    <= ret_pc_d;
      flag_q      <= flag_d;
      sp_q        <= sp_d;
      data_q      <= data_d;
      flg_phase_q <= flg_phase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    target_d    = target_q;
    ret_pc_d    = ret_pc_q;
    flag_d      = flag_q;
    sp_d        = sp_q;
    data_d      = data_q;
    flg_phase_d = flg_phase_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          target_d = target;
          ret_pc_d = ret_pc;
          flag_d   = flags_in;
          sp_d     = sp_in;
          case (op)
            OP_CALL, OP_INT: state_d = S_PUSH_PC;
            OP_RET:          state_d = S_POP_PC;
            default:         state_d = S_POP_FLG;
          endcase
        end
      end
      S_PUSH_PC: begin
        sp_d    = sp_q - 8'd1;
        state_d = (op_q == OP_INT) ? S_PUSH_FLG : S_FIN;
      end
      S_PUSH_FLG: begin
        sp_d    = sp_q - 8'd1;
        state_d = S_RD_VEC;
      end
      S_RD_VEC: state_d = S_RD_WAIT;
      S_POP_FLG: begin
        sp_d        = sp_q + 8'd1;
        flg_phase_d = 1'b1;
        state_d     = S_RD_WAIT;
      end
      S_POP_PC: begin
        sp_d    = sp_q + 8'd1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // The first RTI read returns the flags; the PC pop follows.
        if (flg_phase_q) begin
          flg_phase_d = 1'b0;
          state_d     = S_POP_PC;
        end else begin
          data_d  = mem_rdata;
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    stall     = (state_q != S_IDLE);
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    sp_out    = 8'h00;
    sp_we     = 1'b0;
    pc_load   = 1'b0;
    pc_value  = 8'h00;
    flags_out = '0;
    flags_we  = 1'b0;
    done      = 1'b0;
    int_ack   = 1'b0;
    case (state_q)
      S_PUSH_PC: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = ret_pc_q;
        sp_we     = 1'b1;
        sp_out    = sp_q - 8'd1;
      end
      S_PUSH_FLG: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = 8'(flag_q);
        sp_we     = 1'b1;
        sp_out    = sp_q - 8'd1;
      end
      S_RD_VEC: begin
        mem_re   = 1'b1;
        mem_addr = INT_VEC_ADDR;
      end
      S_POP_FLG, S_POP_PC: begin
        mem_re   = 1'b1;
        mem_addr = sp_q + 8'd1;
        sp_we    = 1'b1;
        sp_out   = sp_q + 8'd1;
      end
      S_RD_WAIT: begin
        if (flg_phase_q) begin
          flags_we  = 1'b1;
          flags_out = mem_rdata[FLAG_W-1:0];
        end
      end
      S_FIN: begin
        pc_load  = 1'b1;
        done     = 1'b1;
        pc_value = (op_q == OP_CALL) ? target_q : data_q;
        int_ack  = (op_q == OP_INT);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_seq_ctrl
// Brief    : Directed vector bench for stack_seq_ctrl with a byte-wide memory.
// Revision : 1.0
// ============================================================================
module tb_stack_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] target, ret_pc, sp_in, mem_rdata;
  logic [3:0] flags_in;
  logic       busy, stall, mem_we, mem_re, sp_we, pc_load, flags_we, done, int_ack;
  logic [7:0] mem_addr, mem_wdata, sp_out, pc_value;
  logic [3:0] flags_out;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_seq_ctrl #(.INT_VEC_ADDR(8'h01), .FLAG_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .target(target),
    .ret_pc(ret_pc), .flags_in(flags_in), .sp_in(sp_in), .mem_rdata(mem_rdata),
    .busy(busy), .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .sp_out(sp_out), .sp_we(sp_we),
    .pc_load(pc_load), .pc_value(pc_value), .flags_out(flags_out),
    .flags_we(flags_we), .done(done), .int_ack(int_ack)
  );

  // Synchronous memory: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] target;
    logic [7:0] ret_pc;
    logic [3:0] flags;
    logic [7:0] sp;
    bit         inject;
    int         lat;
    logic [7:0] pc;
    logic [7:0] sp_fin;
    int         n_we;
    int         n_re;
    int         n_spwe;
    int         n_ack;
    int         n_flgwe;
    logic [3:0] flg;
    bit         mchk;
    logic [7:0] maddr;
    logic [7:0] mval;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat, n_we, n_re, n_spwe, n_ack, n_flgwe, n_busy, n_pcl, both, stall_bad;
    logic [7:0] pcv, spv;
    logic [3:0] flg;
    lat = -1; n_we = 0; n_re = 0; n_spwe = 0; n_ack = 0; n_flgwe = 0;
    n_busy = 0; n_pcl = 0; both = 0; stall_bad = 0;
    pcv = 8'h00; spv = 8'h00; flg = 4'h0;
    @(negedge clk);
    op = v.op; target = v.target; ret_pc = v.ret_pc;
    flags_in = v.flags; sp_in = v.sp; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (stall !== busy) stall_bad++;
      if (mem_we && mem_re) both++;
      if (mem_we) n_we++;
      if (mem_re) n_re++;
      if (int_ack) n_ack++;
      if (sp_we) begin n_spwe++; spv = sp_out; end
      if (flags_we) begin n_flgwe++; flg = flags_out; end
      if (pc_load) begin n_pcl++; pcv = pc_value; end
      if (done && lat < 0) lat = c;
      // A start pulse while busy must be ignored.
      start = v.inject && (c == 1);
      if (start) begin op = 2'b01; sp_in = 8'h42; end
    end
    chk({nm, " latency"}, 64'(lat), 64'(v.lat));
    chk({nm, " pc_value"}, 64'(pcv), 64'(v.pc));
    chk({nm, " final sp_out"}, 64'(spv), 64'(v.sp_fin));
    chk({nm, " mem_we count"}, 64'(n_we), 64'(v.n_we));
    chk({nm, " mem_re count"}, 64'(n_re), 64'(v.n_re));
    chk({nm, " sp_we count"}, 64'(n_spwe), 64'(v.n_spwe));
    chk({nm, " int_ack count"}, 64'(n_ack), 64'(v.n_ack));
    chk({nm, " flags_we count"}, 64'(n_flgwe), 64'(v.n_flgwe));
    if (v.n_flgwe > 0) chk({nm, " flags_out"}, 64'(flg), 64'(v.flg));
    chk({nm, " busy cycles"}, 64'(n_busy), 64'(v.lat));
    chk({nm, " pc_load count"}, 64'(n_pcl), 64'd1);
    chk({nm, " we and re overlap"}, 64'(both), 64'd0);
    chk({nm, " stall vs busy"}, 64'(stall_bad), 64'd0);
    if (v.mchk) chk({nm, " memory"}, 64'(mem[v.maddr]), 64'(v.mval));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, stall, mem_we, mem_re, sp_we, pc_load, done, int_ack,
                flags_we, mem_addr, mem_wdata, sp_out, pc_value, flags_out});
  endfunction

  initial begin
    int n_we, n_spwe, n_pcl;
    vec_t fresh;
    //            op     tgt    ret    flg    sp    inj lat pc     spfin  we re sw ak fw flg   mchk addr   val
    vecs[0] = '{2'b00, 8'h20, 8'h13, 4'h0, 8'hFF, 0, 2, 8'h20, 8'hFE, 1, 0, 1, 0, 0, 4'h0, 1, 8'hFF, 8'h13};
    vecs[1] = '{2'b00, 8'h30, 8'h26, 4'h0, 8'hFE, 0, 2, 8'h30, 8'hFD, 1, 0, 1, 0, 0, 4'h0, 1, 8'hFE, 8'h26};
    vecs[2] = '{2'b01, 8'h00, 8'h00, 4'h0, 8'hFD, 0, 3, 8'h26, 8'hFE, 0, 1, 1, 0, 0, 4'h0, 0, 8'h00, 8'h00};
    vecs[3] = '{2'b01, 8'h00, 8'h00, 4'h0, 8'hFE, 0, 3, 8'h13, 8'hFF, 0, 1, 1, 0, 0, 4'h0, 0, 8'h00, 8'h00};
    vecs[4] = '{2'b10, 8'h00, 8'h40, 4'hA, 8'hFF, 0, 5, 8'h80, 8'hFD, 2, 1, 2, 1, 0, 4'h0, 1, 8'hFE, 8'h0A};
    vecs[5] = '{2'b11, 8'h00, 8'h00, 4'h0, 8'hFD, 0, 5, 8'h40, 8'hFF, 0, 2, 2, 0, 1, 4'hA, 1, 8'hFF, 8'h40};
    vecs[6] = '{2'b00, 8'h66, 8'h55, 4'h0, 8'h00, 1, 2, 8'h66, 8'hFF, 1, 0, 1, 0, 0, 4'h0, 1, 8'h00, 8'h55};
    vecs[7] = '{2'b01, 8'h00, 8'h00, 4'h0, 8'hFF, 0, 3, 8'h55, 8'h00, 0, 1, 1, 0, 0, 4'h0, 0, 8'h00, 8'h00};
    fresh   = '{2'b00, 8'h99, 8'h77, 4'h0, 8'h80, 0, 2, 8'h99, 8'h7F, 1, 0, 1, 0, 0, 4'h0, 1, 8'h80, 8'h77};

    rst = 1'b1; start = 1'b0; op = 2'b00; target = 8'h00; ret_pc = 8'h00;
    flags_in = 4'h0; sp_in = 8'h00;
    pre_we = 1'b1; pre_addr = 8'h01; pre_data = 8'h80;
    @(negedge clk);
    chk("reset outputs", all_outs(), 64'd0);
    @(negedge clk);
    pre_we = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    chk("INT pushed PC kept", 64'(mem[8'hFF]), 64'h40);

    // Reset during the flag push of an INT.
    @(negedge clk);
    op = 2'b10; ret_pc = 8'h11; flags_in = 4'h5; sp_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-reset PUSH_FLG strobe", 64'({mem_we, sp_we, mem_addr}), 64'({1'b1, 1'b1, 8'hFE}));
    #2 rst = 1'b1;
    #1 chk("mid-INT reset outputs", all_outs(), 64'd0);
    n_we = 0; n_spwe = 0; n_pcl = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      if (mem_we) n_we++;
      if (sp_we) n_spwe++;
      if (pc_load || busy) n_pcl++;
    end
    chk("post-reset mem_we", 64'(n_we), 64'd0);
    chk("post-reset sp_we", 64'(n_spwe), 64'd0);
    chk("post-reset busy/pc_load", 64'(n_pcl), 64'd0);
    chk("aborted flag push", 64'(mem[8'hFE]), 64'h0A);
    run_vec("fresh CALL", fresh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_seq_ctrl.md
Name: stack_seq_ctrl

Overview:
- Multi-cycle stack sequencer in the 8-bit pipelined CPU, directly downstream of decode.
- Executes CALL, RET, interrupt entry (INT) and RTI as ordered push/pop sequences on the unified data memory.
- Updates SP (R3) through the register-file write port and redirects the fetch PC.
- Holds the pipeline stalled until the PC redirect is issued.

Parameters:
- INT_VEC_ADDR, 8'h01, memory address holding the interrupt-handler vector.
- FLAG_W, 4, width of the CCR flags saved and restored by INT and RTI.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request from decode; sampled only in IDLE.
- op  in  2  opcode: 00 CALL, 01 RET, 10 INT, 11 RTI.
- target  in  8  CALL destination address (register value).
- ret_pc  in  8  PC value to push (next instruction).
- flags_in  in  FLAG_W  current CCR value.
- sp_in  in  8  current SP (R3).
- mem_rdata  in  8  memory read data; valid 1 cycle after mem_re.
- busy  out  1  sequence in progress.
- stall  out  1  freeze fetch/decode; equals busy.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- sp_out  out  8  new SP value.
- sp_we  out  1  SP write enable.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_value  out  8  redirect target.
- flags_out  out  FLAG_W  restored CCR value.
- flags_we  out  1  CCR restore strobe.
- done  out  1  one-cycle completion pulse, coincident with pc_load.
- int_ack  out  1  one-cycle pulse, coincident with done, INT only.

Behaviour:
- Reset: state IDLE. All outputs 0. Internal sp_r, data_r, flag_r are 0.
- Reset mid-sequence: same as above. No further mem_we or sp_we is issued, and no partial redirect.
- Accepting a request: in IDLE, start=1 latches op, target, ret_pc, flags_in and sp_r<=sp_in. FSM moves to the first state of that op.
- Ignored requests: start is ignored in every other state.
- Stack convention:
  - push: M[SP]<=data, then SP<=SP-1.
  - pop: SP<=SP+1, then data<=M[new SP].
  - All SP arithmetic is mod 256, so 8'h00-1=8'hFF and 8'hFF+1=8'h00, with no error flag.
- States: IDLE, PUSH_PC, PUSH_FLG, RD_VEC, POP_FLG, POP_PC, RD_WAIT, FIN.
- PUSH_PC: mem_we=1, mem_addr=sp_r, mem_wdata=ret_pc, sp_we=1, sp_out=sp_r-1; sp_r<=sp_r-1.
  - Next state is FIN for CALL, PUSH_FLG for INT.
- PUSH_FLG: mem_we=1, mem_addr=sp_r, mem_wdata=zero-extended flags, sp_we=1, sp_out=sp_r-1. Next state RD_VEC.
- RD_VEC: mem_re=1, mem_addr=INT_VEC_ADDR. Next state RD_WAIT.
- POP_FLG (RTI first): mem_re=1, mem_addr=sp_r+1, sp_we=1, sp_out=sp_r+1; sp_r<=sp_r+1. Next state RD_WAIT.
- POP_PC (RET first; RTI second): same pattern as POP_FLG. Next state RD_WAIT.
- RD_WAIT: captures mem_rdata.
  - RTI after POP_FLG: flags_we=1, flags_out=mem_rdata[FLAG_W-1:0], then go to POP_PC.
  - Otherwise: data_r<=mem_rdata, then go to FIN.
- FIN: pc_load=1, done=1, then IDLE (busy drops the next cycle).
  - pc_value=target for CALL; data_r for RET, RTI and INT.
  - int_ack=1 for INT.
- Latency, start to done, in cycles: CALL 2, RET 3, INT 5, RTI 5.
- busy is high from the cycle after start through the FIN cycle inclusive.
- Strobes: mem_we and mem_re are never both high. Each push or pop issues exactly one sp_we.

Test Plan:
- CALL: sp_in=8'hFF, ret_pc=8'h13, target=8'h20 -> M[FF]=13, sp_out=FE; pc_load with pc_value=20 exactly 2 cycles after start; busy high 2 cycles.
- Nested CALL then RETs: CALL (ret 13, tgt 20), then CALL (ret 26, tgt 30) with sp_in=FE -> M[FE]=26. RET with sp_in=FD -> pc_value=26, sp_out=FE. RET with sp_in=FE -> pc_value=13, sp_out=FF; done 3 cycles after each RET start.
- INT: sp_in=8'hFF, ret_pc=8'h40, flags_in=4'b1010, M[01]=8'h80 -> M[FF]=40, M[FE]=0A, final sp_out=FD, pc_value=80, int_ack with done at cycle 5.
- RTI after the INT above: sp_in=FD -> flags_we with flags_out=1010, then pc_value=40, final sp_out=FF, done at cycle 5.
- Wrap and ignore: CALL with sp_in=8'h00 -> write at 00, sp_out=FF. RET with sp_in=FF -> read at 00, sp_out=00. A start pulse while busy causes no extra strobes.
- Reset mid-INT: assert rst in the PUSH_FLG cycle -> all outputs 0 immediately, no further mem_we, FSM idle; a fresh CALL after release completes normally.
